mysystem_start_signal: RTL and testbench



---
 rtl/mysystem_start_pkg.sv | 21 ++
 rtl/mysystem_sync_rise.sv | 25 ++
 rtl/mysystem_start_signal.sv | 117 +++++++++++
 tb/tb_mysystem_start_signal.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mysystem_start_pkg.sv
// Shared constants and types for the start-signal launcher: register map,
// command bit positions and FSM state encoding.
package mysystem_start_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_LEN  = 2'd2;
    localparam logic [1:0] ADDR_CMD  = 2'd3;

    localparam int CMD_GO_BIT  = 0;
    localparam int CMD_CLR_BIT = 1;

    localparam int DEFAULT_LEN = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mysystem_sync_rise.sv
// Two-flop synchronizer for an asynchronous level, with a one-cycle pulse
// on each synchronized rising edge.
module mysystem_sync_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o
);

    logic d1_q;
    logic d2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else begin
            d1_q <= async_i;
            d2_q <= d1_q;
        end
    end

    assign rise_o = d1_q & ~d2_q;

endmodule

// File: rtl/mysystem_start_signal.sv
// Avalon-MM launcher: holds the accelerator parameter word, emits a start
// pulse of programmable length and latches a sticky done flag with optional irq.
module mysystem_start_signal
    import mysystem_start_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic                  done_in,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  start_out,
    output logic                  irq
);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  irq_en_q;
    logic                  done_seen_q;
    logic                  early_q;
    logic                  start_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rd_mux;
    logic                  done_rise;
    logic                  wr;
    logic                  go;
    logic                  clr;
    logic                  busy;

    mysystem_sync_rise u_done_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (done_in),
        .rise_o  (done_rise)
    );

    assign wr   = chipselect & ~write_n;
    assign go   = wr && (address == ADDR_CMD) && writedata[CMD_GO_BIT];
    assign clr  = wr && (address == ADDR_CMD) && writedata[CMD_CLR_BIT];
    assign busy = (state_q != IDLE);

    // Read mux ignores chipselect so readdata always tracks address one cycle late.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[DATA_WIDTH-1:0] = data_q;
            ADDR_CTRL: rd_mux[0] = irq_en_q;
            ADDR_LEN:  rd_mux[LEN_WIDTH-1:0] = len_q;
            default:   rd_mux[1:0] = {busy, done_seen_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            len_q       <= LEN_WIDTH'(DEFAULT_LEN);
            cnt_q       <= '0;
            irq_en_q    <= 1'b0;
            done_seen_q <= 1'b0;
            early_q     <= 1'b0;
            start_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rdata_q <= rd_mux;
            if (wr && address == ADDR_DATA) data_q   <= writedata[DATA_WIDTH-1:0];
            if (wr && address == ADDR_CTRL) irq_en_q <= writedata[0];
            if (wr && address == ADDR_LEN)  len_q    <= writedata[LEN_WIDTH-1:0];
            if (clr) done_seen_q <= 1'b0;

            // Done-flag sets below are later in the block, so they win over CLR_DONE.
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q     <= PULSE;
                        cnt_q       <= (len_q == '0) ? LEN_WIDTH'(1) : len_q;
                        start_q     <= 1'b1;
                        done_seen_q <= 1'b0;
                        early_q     <= 1'b0;
                    end else if (done_rise) begin
                        done_seen_q <= 1'b1;
                    end
                end
                PULSE: begin
                    if (done_rise) early_q <= 1'b1;
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        start_q <= 1'b0;
                        state_q <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                    end
                end
                WAIT_DONE: begin
                    if (done_rise || early_q) begin
                        state_q     <= IDLE;
                        done_seen_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign readdata  = rdata_q;
    assign out_port  = data_q;
    assign start_out = start_q;
    assign irq       = done_seen_q & irq_en_q;

endmodule

// File: tb/tb_mysystem_start_signal.sv
// Self-checking bench for mysystem_start_signal: register reads and start-pulse
// lengths are scored against expected-value queues.
module tb_mysystem_start_signal;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        done_in;
  logic [31:0] out_port;
  logic        start_out;
  logic        irq;

  int n_checks;
  int n_errors;
  int mon_hi;
  int lat;

  logic [31:0] exp_q[$];
  logic [31:0] pulse_q[$];

  mysystem_start_signal #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .done_in    (done_in),
    .out_port   (out_port),
    .start_out  (start_out),
    .irq        (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // driver tasks: all called at a negedge and return at a negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    exp_q.push_back(exp);
    address = a;
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, readdata, e);
  endtask

  task automatic wait_pulse_end();
    for (int i = 0; i < 40 && start_out; i++) @(negedge clk);
    check("pulse_ended", {31'b0, start_out}, 32'h0);
  endtask

  // scoreboard for start pulses: measured length vs queued expectation
  initial begin
    mon_hi = 0;
    forever begin
      @(negedge clk);
      if (start_out) begin
        mon_hi++;
      end else if (mon_hi != 0) begin
        if (pulse_q.size() == 0) check("pulse_unexpected", mon_hi, 0);
        else check("pulse_len", mon_hi, pulse_q.pop_front());
        mon_hi = 0;
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    done_in    = 1'b0;
    repeat (3) tick();
    check("reset_start", {31'b0, start_out}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_out_port", out_port, 32'h0);
    reset_n = 1'b1;

    bus_read(2'd0, 32'h0, "rst_data");
    bus_read(2'd1, 32'h0, "rst_ctrl");
    bus_read(2'd2, 32'h1, "rst_len");
    bus_read(2'd3, 32'h0, "rst_status");

    // basic run, LEN=4, done latency through synchronizer and read register
    bus_write(2'd0, 32'hA5A5_0001);
    check("out_port", out_port, 32'hA5A5_0001);
    bus_write(2'd2, 32'd4);
    bus_read(2'd2, 32'd4, "len_rb");
    pulse_q.push_back(32'd4);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, 32'h2, "status_busy");
    wait_pulse_end();
    done_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (lat == 0 && readdata == 32'h1) lat = i;
    end
    check("done_latency", lat, 32'd3);
    done_in = 1'b0;
    repeat (3) tick();

    // LEN=0 behaves as 1; GO while waiting for done is ignored
    bus_write(2'd2, 32'd0);
    pulse_q.push_back(32'd1);
    bus_write(2'd3, 32'h1);
    wait_pulse_end();
    bus_write(2'd3, 32'h1);
    repeat (4) tick();
    bus_read(2'd3, 32'h2, "go_ignored_status");
    done_in = 1'b1;
    repeat (4) tick();
    done_in = 1'b0;
    repeat (3) tick();
    bus_read(2'd3, 32'h1, "len0_done");

    // done arrives mid-pulse; DATA/LEN writes while busy
    bus_write(2'd2, 32'd10);
    pulse_q.push_back(32'd10);
    bus_write(2'd3, 32'h1);
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h0000_5A5A);
    check("out_port_busy", out_port, 32'h0000_5A5A);
    tick();
    done_in = 1'b1;
    repeat (2) tick();
    done_in = 1'b0;
    wait_pulse_end();
    bus_read(2'd3, 32'h2, "early_wait");
    bus_read(2'd3, 32'h1, "early_done");
    bus_read(2'd2, 32'd3, "len_busy_rb");

    // irq, CLR_DONE colliding with a fresh rise, then CLR_DONE alone
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, 32'h1, "ctrl_rb");
    bus_write(2'd2, 32'd2);
    pulse_q.push_back(32'd2);
    bus_write(2'd3, 32'h1);
    check("irq_cleared_by_go", {31'b0, irq}, 32'h0);
    wait_pulse_end();
    done_in = 1'b1;
    repeat (4) tick();
    check("irq_set", {31'b0, irq}, 32'h1);
    done_in = 1'b0;
    repeat (3) tick();
    bus_write(2'd3, 32'h2);
    check("irq_clr_idle", {31'b0, irq}, 32'h0);
    done_in = 1'b1;
    tick();
    bus_write(2'd3, 32'h2);
    check("irq_set_beats_clr", {31'b0, irq}, 32'h1);
    bus_read(2'd3, 32'h1, "set_beats_clr");
    done_in = 1'b0;
    repeat (3) tick();
    bus_write(2'd3, 32'h2);
    check("irq_after_clr", {31'b0, irq}, 32'h0);
    bus_read(2'd3, 32'h0, "status_cleared");

    // GO+CLR together launches and leaves done_seen clear
    bus_write(2'd2, 32'd1);
    pulse_q.push_back(32'd1);
    bus_write(2'd3, 32'h3);
    bus_read(2'd3, 32'h2, "go_clr_status");
    done_in = 1'b1;
    repeat (4) tick();
    done_in = 1'b0;
    repeat (3) tick();
    bus_write(2'd3, 32'h2);

    // reset in the middle of a pulse
    bus_write(2'd0, 32'h0000_1234);
    bus_write(2'd2, 32'd8);
    pulse_q.push_back(32'd3);
    bus_write(2'd3, 32'h1);
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    check("midrst_start", {31'b0, start_out}, 32'h0);
    check("midrst_out_port", out_port, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;
    bus_read(2'd3, 32'h0, "midrst_status");
    bus_read(2'd2, 32'h1, "midrst_len");
    bus_read(2'd0, 32'h0, "midrst_data");
    bus_read(2'd1, 32'h0, "midrst_ctrl");

    repeat (3) tick();
    check("pulse_q_empty", pulse_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
